// File: rtl/dcache_miss_unit.sv
// Blocking direct-mapped write-through/write-allocate D-cache: load hit answers in the LOOKUP cycle,
// misses fill WORDS beats over the bus then replay; new requests are ignored while data_busy is high.
module dcache_miss_unit #(
    parameter int          ADDR_W = 64,
    parameter int          DATA_W = 64,
    parameter int          LINES  = 16,
    parameter int          WORDS  = 8,
    parameter logic [12:0] TAG_RD = 13'h1100,
    parameter logic [12:0] TAG_WR = 13'h0100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wmask,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                data_busy,
    output logic                data_missed1,
    output logic                data_finished1,
    output logic                bus_reqcyc,
    output logic [DATA_W-1:0]   bus_req,
    output logic [12:0]         bus_reqtag,
    input  logic                bus_reqack,
    input  logic                bus_respcyc,
    input  logic [DATA_W-1:0]   bus_resp,
    output logic                bus_respack
);

    localparam int LSB   = 3;
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - LSB;
    localparam int BYTES = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_WT_ADDR,
        S_WT_DATA
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BYTES-1:0]    wmask_q, wmask_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [OFF_W-1:0]    beat_q, beat_d;
    logic [LINES-1:0]    valid_q, valid_d;

    // Tag and data storage carry no reset: the valid bits alone qualify them.
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [LINES][WORDS];

    logic                line_we;
    logic [OFF_W-1:0]    line_woff;
    logic [DATA_W-1:0]   line_wdat;
    logic                tag_we;

    logic [OFF_W-1:0]    off;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tg;
    logic                hit;
    logic [DATA_W-1:0]   cur_word;
    logic [DATA_W-1:0]   bmask;
    logic [DATA_W-1:0]   merged;
    logic                last_beat;
    logic [ADDR_W-1:0]   line_addr;
    logic [ADDR_W-1:0]   word_addr;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^addr_q[LSB-1:0];

    assign off       = addr_q[LSB +: OFF_W];
    assign idx       = addr_q[LSB+OFF_W +: IDX_W];
    assign tg        = addr_q[ADDR_W-1 -: TAG_W];
    assign hit       = valid_q[idx] && (tag_q[idx] == tg);
    assign cur_word  = data_q[idx][off];
    assign last_beat = (beat_q == OFF_W'(WORDS - 1));
    assign line_addr = {addr_q[ADDR_W-1:LSB+OFF_W], {(LSB+OFF_W){1'b0}}};
    assign word_addr = {addr_q[ADDR_W-1:LSB], {LSB{1'b0}}};

    always_comb begin
        bmask = '0;
        for (int b = 0; b < BYTES; b++) begin
            bmask[b*8 +: 8] = {8{wmask_q[b]}};
        end
    end

    assign merged = (cur_word & ~bmask) | (wdata_q & bmask);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            beat_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[idx][line_woff] <= line_wdat;
        end
        if (tag_we) begin
            tag_q[idx] <= tg;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (req_valid) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (!hit)         state_d = S_FILL_REQ;
                else if (write_q) state_d = S_WT_ADDR;
                else              state_d = S_IDLE;
            end
            S_FILL_REQ:  if (bus_reqack) state_d = S_FILL_WAIT;
            S_FILL_WAIT: if (bus_respcyc && last_beat) state_d = S_LOOKUP;
            S_WT_ADDR:   if (bus_reqack) state_d = S_WT_DATA;
            S_WT_DATA:   if (bus_reqack) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Request capture, line fill and store merge
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        write_d   = write_q;
        rdata_d   = rdata_q;
        beat_d    = beat_q;
        valid_d   = valid_q;
        line_we   = 1'b0;
        line_woff = off;
        line_wdat = merged;
        tag_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    write_d = req_write;
                end
            end
            S_LOOKUP: begin
                if (!hit) begin
                    beat_d = '0;
                end else if (write_q) begin
                    // Merged word goes into the line and is also what gets written through.
                    line_we = 1'b1;
                    wdata_d = merged;
                end else begin
                    rdata_d = cur_word;
                end
            end
            S_FILL_WAIT: begin
                if (bus_respcyc) begin
                    line_we   = 1'b1;
                    line_woff = beat_q;
                    line_wdat = bus_resp;
                    beat_d    = beat_q + 1'b1;
                    if (last_beat) begin
                        tag_we       = 1'b1;
                        valid_d[idx] = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        data_busy      = (state_q != S_IDLE);
        resp_valid     = 1'b0;
        data_missed1   = 1'b0;
        data_finished1 = 1'b0;
        bus_reqcyc     = 1'b0;
        bus_req        = '0;
        bus_reqtag     = '0;
        bus_respack    = 1'b0;
        case (state_q)
            S_LOOKUP: begin
                data_missed1   = !hit;
                resp_valid     = hit && !write_q;
                data_finished1 = hit && !write_q;
            end
            S_FILL_REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = DATA_W'(line_addr);
                bus_reqtag = TAG_RD;
            end
            S_FILL_WAIT: begin
                bus_respack = bus_respcyc;
            end
            S_WT_ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = DATA_W'(word_addr);
                bus_reqtag = TAG_WR;
            end
            S_WT_DATA: begin
                bus_reqcyc     = 1'b1;
                bus_req        = wdata_q;
                bus_reqtag     = TAG_WR;
                data_finished1 = bus_reqack;
            end
            default: ;
        endcase
        resp_rdata = resp_valid ? cur_word : rdata_q;
    end

endmodule

// File: tb/tb_dcache_miss_unit.sv
// Bench for dcache_miss_unit: directed scenarios then random loads/stores, with a bus memory
// slave and a reference model (flat word memory plus per-index valid/tag) kept in the bench.
module tb_dcache_miss_unit;

    localparam logic [12:0] TAG_RD = 13'h1100;
    localparam logic [12:0] TAG_WR = 13'h0100;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        data_busy;
    logic        data_missed1;
    logic        data_finished1;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic        bus_respack;

    dcache_miss_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .data_busy(data_busy), .data_missed1(data_missed1), .data_finished1(data_finished1),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_respack(bus_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [63:0] bus_mem [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];
    bit          ref_vld [16];
    logic [53:0] ref_tag [16];

    function automatic logic [63:0] init_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hC3A5_5A3C, ~a[31:0]};
    endfunction

    function automatic logic [63:0] bus_rd(input logic [63:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One request, end to end, with the bench acting as bus slave cycle by cycle.
    task automatic do_req(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                          input logic [7:0] wm, input int abort_beat);
        logic [63:0] wa, base, exp_rd, exp_wd, fill_addr, wt_addr, wt_data, got_rd;
        int          idx, n, nmiss, nfin, nresp, nreq, nfill, nwt, both, bad_ack, badtag;
        int          miss_n, resp_n, beat;
        bit          exp_miss, done, aborted, beating, wt_got_addr;
        wa       = {a[63:3], 3'b000};
        base     = {a[63:6], 6'b000000};
        idx      = int'(a[9:6]);
        exp_miss = !(ref_vld[idx] && ref_tag[idx] == a[63:10]);
        exp_rd   = ref_rd(wa);
        exp_wd   = merge(exp_rd, wd, wm);
        {n, nmiss, nfin, nresp, nreq, nfill, nwt, both, bad_ack, badtag, miss_n, resp_n, beat} = '0;
        {done, aborted, beating, wt_got_addr} = '0;
        {fill_addr, wt_addr, wt_data, got_rd} = '0;

        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wmask = wm;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;

        while (!done && n < 200) begin
            n++;
            if (abort_beat >= 0 && beating && beat == abort_beat) begin
                bus_reqack  = 1'b0;
                bus_respcyc = 1'b1;
                bus_resp    = bus_rd(fill_addr + 64'(beat) * 8);
                reset       = 1'b1;
                #1;
                chk("rst_respack", bus_respack, 0);
                chk("rst_busy", data_busy, 0);
                chk("rst_reqcyc", bus_reqcyc, 0);
                aborted = 1'b1;
                done    = 1'b1;
            end else begin
                bus_reqack = bus_reqcyc && ($urandom_range(0, 2) != 0);
                if (beating) begin
                    bus_respcyc = ($urandom_range(0, 3) != 0);
                    bus_resp    = bus_rd(fill_addr + 64'(beat) * 8);
                end else begin
                    bus_respcyc = ($urandom_range(0, 5) == 0);
                    bus_resp    = {$urandom, $urandom};
                end
                #1;
                if (bus_respack !== (beating && bus_respcyc)) bad_ack++;
                if (resp_valid === 1'b1) begin nresp++; got_rd = resp_rdata; resp_n = n; end
                if (data_missed1 === 1'b1) begin nmiss++; miss_n = n; end
                if (data_missed1 === 1'b1 && data_finished1 === 1'b1) both++;
                if (data_finished1 === 1'b1) begin nfin++; done = 1'b1; end
                if (beating && bus_respcyc) begin
                    beat++;
                    if (beat == 8) beating = 1'b0;
                end
                if (bus_reqcyc === 1'b1) begin
                    nreq++;
                    if (bus_reqtag != TAG_RD && bus_reqtag != TAG_WR) badtag++;
                    if (bus_reqack) begin
                        if (bus_reqtag == TAG_RD) begin
                            fill_addr = bus_req; nfill++; beating = 1'b1; beat = 0;
                        end else if (bus_reqtag == TAG_WR) begin
                            if (!wt_got_addr) begin
                                wt_addr = bus_req; wt_got_addr = 1'b1;
                            end else begin
                                wt_data = bus_req; bus_mem[wt_addr] = bus_req; nwt++;
                            end
                        end
                    end
                end
                @(negedge clk);
            end
        end
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;

        if (aborted) begin
            repeat (2) @(negedge clk);
            chk("rst_rdata", resp_rdata, 0);
            reset = 1'b0;
            @(negedge clk);
            chk("rst_release_busy", data_busy, 0);
            foreach (ref_vld[i]) ref_vld[i] = 1'b0;
            return;
        end

        chk("timeout", done, 1);
        chk("miss_cnt", nmiss, exp_miss ? 1 : 0);
        chk("fin_cnt", nfin, 1);
        chk("miss_and_fin", both, 0);
        chk("respack", bad_ack, 0);
        chk("bus_tag", badtag, 0);
        if (exp_miss) begin
            chk("miss_cycle", miss_n, 1);
            chk("fill_cnt", nfill, 1);
            chk("fill_addr", fill_addr, base);
        end else begin
            chk("fill_cnt", nfill, 0);
        end
        if (!wr) begin
            chk("resp_cnt", nresp, 1);
            chk("rdata", got_rd, exp_rd);
            chk("rdata_hold", resp_rdata, exp_rd);
            if (!exp_miss) begin
                chk("hit_latency", resp_n, 1);
                chk("hit_bus_idle", nreq, 0);
            end
        end else begin
            chk("resp_cnt", nresp, 0);
            chk("wt_cnt", nwt, 1);
            chk("wt_addr", wt_addr, wa);
            chk("wt_data", wt_data, exp_wd);
            ref_mem[wa] = exp_wd;
        end
        ref_vld[idx] = 1'b1;
        ref_tag[idx] = a[63:10];
    endtask

    initial begin
        logic [63:0] ra, rwd;
        logic [7:0]  rwm;
        bit          rwr;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
        foreach (ref_vld[i]) ref_vld[i] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_mem[64'h1000 + 64'(i) * 8] = 64'hA0 + 64'(i);
            ref_mem[64'h1000 + 64'(i) * 8] = 64'hA0 + 64'(i);
        end

        repeat (3) @(negedge clk);
        chk("reset_busy", data_busy, 0);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_rdata", resp_rdata, 0);
        chk("reset_missed", data_missed1, 0);
        chk("reset_finished", data_finished1, 0);
        chk("reset_reqcyc", bus_reqcyc, 0);
        chk("reset_req", bus_req, 0);
        chk("reset_reqtag", bus_reqtag, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", data_busy, 0);

        do_req(1'b0, 64'h1000, 64'h0, 8'h00, -1);
        do_req(1'b0, 64'h1018, 64'h0, 8'h00, -1);
        do_req(1'b1, 64'h1008, 64'hFFFF, 8'h03, -1);
        do_req(1'b0, 64'h1008, 64'h0, 8'h00, -1);
        do_req(1'b1, 64'h2040, 64'h0123_4567_89AB_CDEF, 8'hA5, -1);
        do_req(1'b0, 64'h2040, 64'h0, 8'h00, -1);
        do_req(1'b0, 64'h1400, 64'h0, 8'h00, -1);
        do_req(1'b0, 64'h1000, 64'h0, 8'h00, -1);
        do_req(1'b0, 64'h1400, 64'h0, 8'h00, 4);
        do_req(1'b0, 64'h1000, 64'h0, 8'h00, -1);

        for (int k = 0; k < 80; k++) begin
            ra  = (64'($urandom_range(4, 6)) << 10) | (64'($urandom_range(0, 3)) << 6)
                | (64'($urandom_range(0, 7)) << 3) | 64'($urandom_range(0, 7));
            rwr = ($urandom_range(0, 2) == 0);
            rwd = {$urandom, $urandom};
            rwm = 8'($urandom);
            do_req(rwr, ra, rwd, rwm, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
